legv8_fetch_decode: RTL
=======================

Name: legv8_fetch_decode

Overview:
- Reader and decoder side of the LEGv8 byte-wide instruction store.
- Fetches one 32-bit instruction as four little-endian byte reads:
  - address pc+0 supplies bits 7:0.
  - address pc+3 supplies bits 31:24.
- Classifies the instruction into R/I/D/B/CB/IW format and extracts register fields and a 64-bit immediate.
- Presents the result on a valid/ready output to the core pipeline.

Parameters:
- ADDR_W, 64, width of the PC and memory address (LEGv8 integer size).
- IMM_W, 64, width of the decoded immediate.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request.
- req_ready  out  1  block can accept a request.
- req_pc  in  ADDR_W  byte address of the instruction.
- flush  in  1  synchronous abort of the in-flight fetch.
- mem_rd_en  out  1  byte read strobe.
- mem_addr  out  ADDR_W  byte read address.
- mem_rdata  in  8  read data, valid the cycle after mem_rd_en.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  consumer accepts.
- out_pc  out  ADDR_W  PC of the decoded instruction.
- out_instr  out  32  assembled instruction word.
- out_fmt  out  3  format: 0 R, 1 I, 2 D, 3 B, 4 CB, 5 IW, 7 ERR.
- out_opcode  out  11  instr[31:21].
- out_rd  out  5  instr[4:0] (Rd/Rt).
- out_rn  out  5  instr[9:5].
- out_rm  out  5  instr[20:16].
- out_imm  out  IMM_W  decoded immediate.
- out_misaligned  out  1  req_pc[1:0] != 0.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - State IDLE, byte counter 0.
  - req_ready=1; mem_rd_en=0.
  - mem_addr, out_valid and all out_* outputs = 0.
- States: IDLE, READ, WAIT, DONE.
- req_ready = (state==IDLE) | (state==DONE & out_ready).
- A request is accepted on a rising edge with req_valid & req_ready; call that edge E0.
- Aligned request:
  - E0: pc latched, state READ, cnt=0.
  - READ: mem_rd_en=1, mem_addr=pc+cnt; cnt increments each edge. After the cnt=3 cycle the state goes to WAIT.
  - Byte k is captured into assembly byte lane k at edge E(k+2).
  - Byte 3 is captured at E5; all out_* registers load at E5; state DONE; out_valid=1.
  - Latency is 5 cycles from acceptance to out_valid.
- Misaligned request:
  - No memory reads are issued.
  - Next edge: DONE with out_fmt=7, out_misaligned=1, out_pc=req_pc, out_instr=0, out_imm=0.
- DONE:
  - out_* are stable while out_valid & !out_ready.
  - On out_valid & out_ready: if req_valid, start a new fetch on the same edge; otherwise go to IDLE with out_valid=0.
  - Back-to-back throughput is one instruction per 6 cycles.
- mem_rd_en=0 in IDLE, WAIT and DONE.
- mem_addr holds its last value outside READ.
- Address arithmetic wraps modulo 2^ADDR_W.
- flush takes priority over everything:
  - Next edge: state IDLE, out_valid=0, no further reads.
  - Read data for a read already issued is discarded.
  - A req_valid in the flush cycle is ignored.
- Format priority, first match wins:
  - B: instr[31:26] in {000101, 100101}.
  - CB: instr[31:24] in {8'hB4, 8'hB5, 8'h54}.
  - IW: instr[31:23] in {9'b110100101, 9'b111100101}.
  - I: instr[31:22] in {0x244, 0x2C4, 0x344, 0x3C4, 0x248, 0x3C8, 0x2C8, 0x348}.
  - D: instr[31:21] in {0x7C0, 0x7C2, 0x5C0, 0x5C4, 0x3C0, 0x3C2, 0x1C0, 0x1C2, 0x640, 0x642}.
  - Anything else is R.
- Immediate:
  - R: zero-extended shamt instr[15:10].
  - I: zero-extended instr[21:10].
  - D: sign-extended instr[20:12].
  - B: sign-extended instr[25:0] shifted left 2.
  - CB: sign-extended instr[23:5] shifted left 2.
  - IW: zero-extended instr[20:5] shifted left by 16 x instr[22:21].
  - ERR: 0.
- Register fields always reflect the instruction bits, whatever the format.

Test Plan:
- Reset mid-READ (rst pulsed asynchronously) → mem_rd_en=0 and out_valid=0 immediately; req_ready=1 after release.
- Memory bytes 49 D7 9F D2 at pc=0, out_ready=1:
  - mem_addr 0,1,2,3 on consecutive cycles.
  - out_valid 5 cycles after acceptance.
  - Expect out_instr=0xD29FD749, fmt=5, rd=9, imm=0xFEBA.
- 0x91001441 at pc=0x10 → fmt=1, rd=1, rn=2, imm=5, out_pc=0x10.
- 0xF85F8083 (LDUR) → fmt=2, rd=3, rn=4, imm=0xFFFFFFFFFFFFFFF8.
- 0x17FFFFFF, then 0xB4000045:
  - First: fmt=3, imm=-4.
  - Second: fmt=4, rd=5, imm=8.
  - Second request held on req_valid during the first's handshake edge is accepted on that edge.
- Backpressure and error paths:
  - out_ready low 3 cycles → all out_* stable.
  - flush asserted in the cnt=1 cycle → IDLE next edge, no out_valid.
  - req_pc=0x2 → no mem_rd_en; fmt=7, misaligned=1 one cycle after acceptance.

Source files
------------

// File: rtl/legv8_fetch_decode.sv
// -----------------------------------------------------------------------------
// legv8_fetch_decode
//
// Instruction fetch and decode front end for a byte-wide LEGv8 instruction
// store. An accepted request reads four bytes little-endian (pc+0 holds bits
// 7:0, pc+3 holds bits 31:24). The block then classifies the word as R/I/D/B/CB/IW,
// extracts the register fields and the 64-bit immediate, and holds the result
// on a valid/ready output until the pipeline takes it.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   fetch request handshake; req_pc is the byte address
//   flush             abort any in-flight fetch, return to IDLE next edge
//   mem_rd_en/addr    byte read strobe and address (addr holds outside READ)
//   mem_rdata         read byte, valid the cycle after mem_rd_en
//   out_valid/ready   decoded-instruction handshake
//   out_pc/instr      PC and assembled 32-bit word
//   out_fmt           0 R, 1 I, 2 D, 3 B, 4 CB, 5 IW, 7 error (misaligned)
//   out_opcode/rd/rn/rm  raw instruction fields
//   out_imm           decoded immediate
//   out_misaligned    request PC was not word aligned
// -----------------------------------------------------------------------------
module legv8_fetch_decode #(
    parameter int ADDR_W = 64,
    parameter int IMM_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic              flush,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    output logic [2:0]        out_fmt,
    output logic [10:0]       out_opcode,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rn,
    output logic [4:0]        out_rm,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_D   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_CB  = 3'd4;
    localparam logic [2:0] FMT_IW  = 3'd5;
    localparam logic [2:0] FMT_ERR = 3'd7;

    state_t             state_reg, state_next;
    logic [1:0]         cnt_reg, cnt_next;
    logic [ADDR_W-1:0]  pc_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic               rd_pending_reg;
    logic [1:0]         rd_lane_reg;

    logic               out_valid_reg;
    logic [ADDR_W-1:0]  out_pc_reg;
    logic [31:0]        out_instr_reg;
    logic [2:0]         out_fmt_reg;
    logic [IMM_W-1:0]   out_imm_reg;
    logic               out_misaligned_reg;

    logic               take_req;
    logic               start_read;
    logic               load_decoded;
    logic               load_misaligned;
    logic [23:0]        low_bytes;
    logic [31:0]        word_full;
    logic [2:0]         dec_fmt;
    logic [IMM_W-1:0]   dec_imm;

    assign req_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign take_req  = req_valid && req_ready;
    assign mem_rd_en = (state_reg == READ);

    // Byte lanes 0..2 are captured the cycle after their read. Lane 3 is never
    // stored: it is consumed straight off mem_rdata when the outputs load.
    // A flush on the capture edge discards the returning byte.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] byte_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    byte_reg <= '0;
                end else if (rd_pending_reg && !flush && (rd_lane_reg == 2'(gi))) begin
                    byte_reg <= mem_rdata;
                end
            end
            assign low_bytes[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    assign word_full = {mem_rdata, low_bytes};

    // Next-state logic. flush overrides everything, including a request
    // presented in the same cycle.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        start_read      = 1'b0;
        load_decoded    = 1'b0;
        load_misaligned = 1'b0;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = 2'd0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (take_req) begin
                        if (req_pc[1:0] == 2'b00) begin
                            state_next = READ;
                            cnt_next   = 2'd0;
                            start_read = 1'b1;
                        end else begin
                            state_next      = DONE;
                            load_misaligned = 1'b1;
                        end
                    end else if ((state_reg == DONE) && out_ready) begin
                        state_next = IDLE;
                    end
                end
                READ: begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    // Byte 3 arrives in this cycle; outputs load on this edge.
                    state_next   = DONE;
                    load_decoded = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Format classification, first match wins.
    always_comb begin
        dec_fmt = FMT_R;
        dec_imm = IMM_W'(word_full[15:10]);
        if (word_full[31:26] inside {6'b000101, 6'b100101}) begin
            dec_fmt = FMT_B;
            dec_imm = {{(IMM_W-28){word_full[25]}}, word_full[25:0], 2'b00};
        end else if (word_full[31:24] inside {8'hB4, 8'hB5, 8'h54}) begin
            dec_fmt = FMT_CB;
            dec_imm = {{(IMM_W-21){word_full[23]}}, word_full[23:5], 2'b00};
        end else if (word_full[31:23] inside {9'b110100101, 9'b111100101}) begin
            dec_fmt = FMT_IW;
            dec_imm = IMM_W'(word_full[20:5]) << {word_full[22:21], 4'b0000};
        end else if (word_full[31:22] inside {10'h244, 10'h2C4, 10'h344, 10'h3C4,
                                               10'h248, 10'h3C8, 10'h2C8, 10'h348}) begin
            dec_fmt = FMT_I;
            dec_imm = IMM_W'(word_full[21:10]);
        end else if (word_full[31:21] inside {11'h7C0, 11'h7C2, 11'h5C0, 11'h5C4, 11'h3C0,
                                               11'h3C2, 11'h1C0, 11'h1C2, 11'h640, 11'h642}) begin
            dec_fmt = FMT_D;
            dec_imm = {{(IMM_W-9){word_full[20]}}, word_full[20:12]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 2'd0;
            pc_reg         <= '0;
            mem_addr_reg   <= '0;
            rd_pending_reg <= 1'b0;
            rd_lane_reg    <= 2'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            rd_pending_reg <= mem_rd_en && !flush;
            rd_lane_reg    <= cnt_reg;
            if (start_read) begin
                pc_reg       <= req_pc;
                mem_addr_reg <= req_pc;
            end else if ((state_reg == READ) && (cnt_reg != 2'd3) && !flush) begin
                // Stops at pc+3 so the address holds its last read value.
                mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg      <= 1'b0;
            out_pc_reg         <= '0;
            out_instr_reg      <= '0;
            out_fmt_reg        <= FMT_R;
            out_imm_reg        <= '0;
            out_misaligned_reg <= 1'b0;
        end else begin
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (load_decoded) begin
                out_valid_reg      <= 1'b1;
                out_pc_reg         <= pc_reg;
                out_instr_reg      <= word_full;
                out_fmt_reg        <= dec_fmt;
                out_imm_reg        <= dec_imm;
                out_misaligned_reg <= 1'b0;
            end else if (load_misaligned) begin
                out_valid_reg      <= 1'b1;
                out_pc_reg         <= req_pc;
                out_instr_reg      <= '0;
                out_fmt_reg        <= FMT_ERR;
                out_imm_reg        <= '0;
                out_misaligned_reg <= 1'b1;
            end else if ((state_reg == DONE) && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign mem_addr       = mem_addr_reg;
    assign out_valid      = out_valid_reg;
    assign out_pc         = out_pc_reg;
    assign out_instr      = out_instr_reg;
    assign out_fmt        = out_fmt_reg;
    assign out_opcode     = out_instr_reg[31:21];
    assign out_rd         = out_instr_reg[4:0];
    assign out_rn         = out_instr_reg[9:5];
    assign out_rm         = out_instr_reg[20:16];
    assign out_imm        = out_imm_reg;
    assign out_misaligned = out_misaligned_reg;

endmodule
